// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default pointer width, Gray/binary conversion and
// status-flag reset values, used by both the read and the write controllers.
package fifo_pkg;

    localparam int PTR_WIDTH = 8;

    // Conversions work on a wide vector; callers zero-extend and size-cast back,
    // which keeps them correct for any pointer width up to GRAY_MAXW.
    localparam int GRAY_MAXW = 32;

    localparam logic EMPTY_RST_VAL     = 1'b1;
    localparam logic AEMPTY_RST_VAL    = 1'b1;
    localparam logic UNDERFLOW_RST_VAL = 1'b0;

    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, memory address and
// empty / almost-empty / level status. Sticky underflow flag when FIFO_RD_UNDERFLOW_EN is defined.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ptr_width     = PTR_WIDTH,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                 rdclk,
    input  logic                 rd_rst,
    input  logic                 rd_en,
    input  logic [ptr_width:0]   wptr_sync,
    output logic [ptr_width:0]   rptr,
    output logic [ptr_width-1:0] raddr,
    output logic                 rd_empty,
    output logic                 rd_almost_empty,
    output logic [ptr_width:0]   rd_level,
    output logic                 rd_underflow
);

    localparam int PW = ptr_width + 1;

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_level;
    logic          r_empty;
    logic          r_aempty;

    logic          w_rd_fire;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_level_next;

    assign w_rd_fire    = rd_en & ~r_empty;
    assign w_rbin_next  = r_rbin + PW'(w_rd_fire);
    assign w_rgray_next = PW'(bin2gray(GRAY_MAXW'(w_rbin_next)));
    assign w_wbin       = PW'(gray2bin(GRAY_MAXW'(wptr_sync)));
    // Wrap bit included, so a full FIFO yields 2**ptr_width rather than 0.
    assign w_level_next = w_wbin - w_rbin_next;

    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            r_rbin   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_empty  <= EMPTY_RST_VAL;
            r_aempty <= AEMPTY_RST_VAL;
        end else begin
            r_rbin   <= w_rbin_next;
            r_rptr   <= w_rgray_next;
            r_level  <= w_level_next;
            r_empty  <= (w_rgray_next == wptr_sync);
            r_aempty <= (w_level_next <= PW'(AEMPTY_THRESH));
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    logic r_underflow;

    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            r_underflow <= UNDERFLOW_RST_VAL;
        end else if (rd_en && r_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign rd_underflow = r_underflow;
`else
    assign rd_underflow = 1'b0;
`endif

    assign rptr            = r_rptr;
    assign raddr           = r_rbin[ptr_width-1:0];
    assign rd_empty        = r_empty;
    assign rd_almost_empty = r_aempty;
    assign rd_level        = r_level;

endmodule
